ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver that tracks up to two held keys (make/break, E0 prefix filtering).
// Optional frame timeout enabled by defining PS2_TIMEOUT_EN.
module ps2_key_tracker #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd50000
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode1,
    output logic [7:0] keycode2,
    output logic       key_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic        clk_s1_q, clk_s1_d;
    logic        clk_s2_q, clk_s2_d;
    logic        clk_hist_q, clk_hist_d;
    logic        dat_s1_q, dat_s1_d;
    logic        dat_s2_q, dat_s2_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic        accept_q, accept_d;
    logic [7:0]  byte_q, byte_d;
    logic        brk_q, brk_d;
    logic        ext_q, ext_d;
    logic [7:0]  keycode1_q, keycode1_d;
    logic [7:0]  keycode2_q, keycode2_d;
    logic        key_valid_q, key_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        fall;

`ifdef PS2_TIMEOUT_EN
    logic [19:0] to_cnt_q, to_cnt_d;
`else
    wire unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign fall = clk_hist_q & ~clk_s2_q;

    always_comb begin
        clk_s1_d    = ps2_clk;
        clk_s2_d    = clk_s1_q;
        clk_hist_d  = clk_s2_q;
        dat_s1_d    = ps2_data;
        dat_s2_d    = dat_s1_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        accept_d    = 1'b0;
        byte_d      = byte_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        keycode1_d  = keycode1_q;
        keycode2_d  = keycode2_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    parity_d = dat_s2_q;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (dat_s2_q && (^{shift_q, parity_q})) begin
                        accept_d = 1'b1;
                        byte_d   = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Key table update runs one cycle after the stop-bit edge.
        if (accept_q) begin
            case (byte_q)
                8'hF0: brk_d = 1'b1;
                8'hE0: ext_d = 1'b1;
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
                default: begin
                    if (!ext_q) begin
                        if (!brk_q) begin
                            if (byte_q != keycode1_q && byte_q != keycode2_q) begin
                                if (keycode1_q == 8'h00) begin
                                    keycode1_d = byte_q;
                                end else if (keycode2_q == 8'h00) begin
                                    keycode2_d = byte_q;
                                end
                            end
                        end else begin
                            if (keycode1_q == byte_q) keycode1_d = 8'h00;
                            if (keycode2_q == byte_q) keycode2_d = 8'h00;
                        end
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            endcase
            key_valid_d = (keycode1_d != keycode1_q) || (keycode2_d != keycode2_q);
        end

`ifdef PS2_TIMEOUT_EN
        if (state_q == S_IDLE || fall) begin
            to_cnt_d = 20'd0;
        end else begin
            to_cnt_d = to_cnt_q + 20'd1;
        end
        if (state_q != S_IDLE && !fall && to_cnt_q == TIMEOUT_CYCLES - 20'd1) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            brk_d       = 1'b0;
            ext_d       = 1'b0;
            to_cnt_d    = 20'd0;
        end
`endif
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_hist_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            accept_q    <= 1'b0;
            byte_q      <= 8'h00;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            keycode1_q  <= 8'h00;
            keycode2_q  <= 8'h00;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            to_cnt_q    <= 20'd0;
`endif
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_hist_q  <= clk_hist_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            accept_q    <= accept_d;
            byte_q      <= byte_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            keycode1_q  <= keycode1_d;
            keycode2_q  <= keycode2_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
`ifdef PS2_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign keycode1  = keycode1_q;
    assign keycode2  = keycode2_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: table of frames with expected slots/pulses plus hand sequences.
module tb_ps2_key_tracker;

    localparam logic [19:0] TO = 20'd100;

    logic       vga_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode1, keycode2;
    logic       key_valid, frame_err;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode1  (keycode1),
        .keycode2  (keycode2),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        logic [7:0] k1;
        logic [7:0] k2;
        int         kv;
        int         fe;
    } vec_t;

    localparam int NV = 30;
    vec_t vt [NV];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int kv_cnt, fe_cnt, kv_lat;
    int both_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge vga_clk);
        cyc++;
        if (key_valid) begin
            kv_cnt++;
            if (kv_lat < 0) kv_lat = cyc - stop_cyc;
        end
        if (frame_err) fe_cnt++;
        if (key_valid && frame_err) both_cnt++;
    endtask

    task automatic bit_out(input logic b, input bit is_stop);
        ps2_data = b;
        repeat (4) tick();
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        repeat (8) tick();
        ps2_clk = 1'b1;
        repeat (4) tick();
    endtask

    task automatic clear_counts();
        kv_cnt = 0;
        fe_cnt = 0;
        kv_lat = -1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        clear_counts();
        bit_out(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bit_out(code[i], 1'b0);
        bit_out((~^code) ^ bad_par, 1'b0);
        bit_out(~bad_stop, 1'b1);
        ps2_data = 1'b1;
        repeat (10) tick();
    endtask

    task automatic send_bits(input logic [7:0] code, input int n);
        bit_out(1'b0, 1'b0);
        for (int i = 0; i < n; i++) bit_out(code[i], 1'b0);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        vt[0]  = '{8'h1D, 0, 0, 8'h1D, 8'h00, 1, 0};
        vt[1]  = '{8'h4B, 0, 0, 8'h1D, 8'h4B, 1, 0};
        vt[2]  = '{8'h44, 0, 0, 8'h1D, 8'h4B, 0, 0};
        vt[3]  = '{8'hF0, 0, 0, 8'h1D, 8'h4B, 0, 0};
        vt[4]  = '{8'h1D, 0, 0, 8'h00, 8'h4B, 1, 0};
        vt[5]  = '{8'h44, 0, 0, 8'h44, 8'h4B, 1, 0};
        vt[6]  = '{8'h1B, 1, 0, 8'h44, 8'h4B, 0, 1};
        vt[7]  = '{8'h1B, 0, 1, 8'h44, 8'h4B, 0, 1};
        vt[8]  = '{8'hE0, 0, 0, 8'h44, 8'h4B, 0, 0};
        vt[9]  = '{8'h75, 0, 0, 8'h44, 8'h4B, 0, 0};
        vt[10] = '{8'hE0, 0, 0, 8'h44, 8'h4B, 0, 0};
        vt[11] = '{8'hF0, 0, 0, 8'h44, 8'h4B, 0, 0};
        vt[12] = '{8'h75, 0, 0, 8'h44, 8'h4B, 0, 0};
        vt[13] = '{8'hF0, 0, 0, 8'h44, 8'h4B, 0, 0};
        vt[14] = '{8'h44, 0, 0, 8'h00, 8'h4B, 1, 0};
        vt[15] = '{8'h1B, 0, 0, 8'h1B, 8'h4B, 1, 0};
        vt[16] = '{8'hF0, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[17] = '{8'h4B, 0, 0, 8'h1B, 8'h00, 1, 0};
        vt[18] = '{8'h4B, 0, 0, 8'h1B, 8'h4B, 1, 0};
        vt[19] = '{8'h4B, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[20] = '{8'h4B, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[21] = '{8'hF0, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[22] = '{8'hAA, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[23] = '{8'h1B, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[24] = '{8'hF0, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[25] = '{8'h33, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[26] = '{8'h33, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[27] = '{8'hF0, 0, 0, 8'h1B, 8'h4B, 0, 0};
        vt[28] = '{8'h1B, 0, 0, 8'h00, 8'h4B, 1, 0};
        vt[29] = '{8'h33, 0, 0, 8'h33, 8'h4B, 1, 0};

        clear_counts();
        repeat (2) tick();
        check("rst_keycode1", keycode1, 8'h00);
        check("rst_keycode2", keycode2, 8'h00);
        check("rst_key_valid", key_valid, 0);
        check("rst_frame_err", frame_err, 0);
        do_reset();

        // Single make code: one pulse, four cycles after the stop-bit fall.
        send_frame(8'h1D, 0, 0);
        check("first_k1", keycode1, 8'h1D);
        check("first_k2", keycode2, 8'h00);
        check("first_kv_count", kv_cnt, 1);
        check("first_kv_latency", kv_lat, 4);
        check("first_fe_count", fe_cnt, 0);

        do_reset();
        for (int i = 0; i < NV; i++) begin
            send_frame(vt[i].code, vt[i].bad_par, vt[i].bad_stop);
            check($sformatf("vec%0d_k1", i), keycode1, vt[i].k1);
            check($sformatf("vec%0d_k2", i), keycode2, vt[i].k2);
            check($sformatf("vec%0d_kv", i), kv_cnt, vt[i].kv);
            check($sformatf("vec%0d_fe", i), fe_cnt, vt[i].fe);
        end

        // Reset in the middle of a frame, then a clean frame.
        send_bits(8'h4B, 4);
        sys_rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (2) tick();
        check("midrst_k1", keycode1, 8'h00);
        check("midrst_k2", keycode2, 8'h00);
        check("midrst_kv", key_valid, 0);
        check("midrst_fe", frame_err, 0);
        sys_rst_n = 1'b1;
        repeat (3) tick();
        send_frame(8'h1D, 0, 0);
        check("postrst_k1", keycode1, 8'h1D);
        check("postrst_k2", keycode2, 8'h00);
        check("postrst_kv", kv_cnt, 1);

`ifdef PS2_TIMEOUT_EN
        // Abandon a frame after four data bits and let the timeout fire.
        send_bits(8'h4B, 4);
        ps2_data = 1'b1;
        clear_counts();
        repeat (int'(TO) + 20) tick();
        check("timeout_fe", fe_cnt, 1);
        check("timeout_kv", kv_cnt, 0);
        check("timeout_k1", keycode1, 8'h1D);
        send_frame(8'h4B, 0, 0);
        check("after_to_k1", keycode1, 8'h1D);
        check("after_to_k2", keycode2, 8'h4B);
        check("after_to_kv", kv_cnt, 1);
        check("after_to_fe", fe_cnt, 0);
`endif

        check("kv_fe_overlap", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
